id_alu_issue: RTL and testbench

//  Decode stage that produces the ALU's operation code and operands. Decodes a 32-bit MIPS

---
 rtl/id_alu_issue.sv | 130 +++++++++++++
 tb/tb_id_alu_issue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/id_alu_issue.sv
// Decode stage: turns a MIPS instruction into an ALU op, two operands and a destination.
// The result is registered into ID/EX, with stall/flush controls and a saturating illegal counter.
module id_alu_issue #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       if_instr,
   input  logic              if_valid,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic              stall,
   input  logic              flush,
   output logic              ex_valid,
   output logic [5:0]        ex_alu_op,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [4:0]        ex_rd,
   output logic              ex_reg_write,
   output logic              ex_illegal,
   output logic [CNT_W-1:0]  illegal_cnt
);

   logic [5:0]        opcode, funct;
   logic [15:0]       imm;
   logic [DATA_W-1:0] sext, zext, shamt_z;
   logic [5:0]        d_op;
   logic [DATA_W-1:0] d_a, d_b;
   logic [4:0]        d_rd;
   logic              d_legal;

   assign opcode  = if_instr[31:26];
   assign funct   = if_instr[5:0];
   assign imm     = if_instr[15:0];
   assign sext    = {{(DATA_W-16){imm[15]}}, imm};
   assign zext    = {{(DATA_W-16){1'b0}}, imm};
   assign shamt_z = {{(DATA_W-5){1'b0}}, if_instr[10:6]};

   // Illegal encodings fall through with d_legal=0 and bubble fields.
   always_comb begin
      d_op    = 6'b000000;
      d_a     = '0;
      d_b     = '0;
      d_rd    = 5'd0;
      d_legal = 1'b0;
      case (opcode)
         6'b000000: begin
            case (funct)
               6'b100000, 6'b100001, 6'b100010, 6'b100011,
               6'b100100, 6'b100101, 6'b100110, 6'b100111,
               6'b101010, 6'b101011: begin
                  d_op    = funct;
                  d_a     = rs_data;
                  d_b     = rt_data;
                  d_rd    = if_instr[15:11];
                  d_legal = 1'b1;
               end
               6'b000000, 6'b000010, 6'b000011: begin
                  d_op    = funct;
                  d_a     = rt_data;
                  d_b     = shamt_z;
                  d_rd    = if_instr[15:11];
                  d_legal = 1'b1;
               end
               6'b000100, 6'b000110, 6'b000111: begin
                  d_op    = funct;
                  d_a     = rt_data;
                  d_b     = rs_data;
                  d_rd    = if_instr[15:11];
                  d_legal = 1'b1;
               end
               default: d_legal = 1'b0;
            endcase
         end
         6'b001000: begin d_op = 6'b100000; d_a = rs_data; d_b = sext; d_rd = if_instr[20:16]; d_legal = 1'b1; end
         6'b001001: begin d_op = 6'b100001; d_a = rs_data; d_b = sext; d_rd = if_instr[20:16]; d_legal = 1'b1; end
         6'b001010: begin d_op = 6'b101010; d_a = rs_data; d_b = sext; d_rd = if_instr[20:16]; d_legal = 1'b1; end
         6'b001011: begin d_op = 6'b101011; d_a = rs_data; d_b = sext; d_rd = if_instr[20:16]; d_legal = 1'b1; end
         6'b001100: begin d_op = 6'b100100; d_a = rs_data; d_b = zext; d_rd = if_instr[20:16]; d_legal = 1'b1; end
         6'b001101: begin d_op = 6'b100101; d_a = rs_data; d_b = zext; d_rd = if_instr[20:16]; d_legal = 1'b1; end
         6'b001110: begin d_op = 6'b100110; d_a = rs_data; d_b = zext; d_rd = if_instr[20:16]; d_legal = 1'b1; end
         // LUI is executed as imm << 16 on the shifter.
         6'b001111: begin d_op = 6'b000000; d_a = zext; d_b = DATA_W'(16); d_rd = if_instr[20:16]; d_legal = 1'b1; end
         default:   d_legal = 1'b0;
      endcase
   end

   // Priority: reset > flush > stall > load. Stall holds every ex_* output and the counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid     <= 1'b0;
         ex_alu_op    <= 6'b000000;
         ex_a         <= '0;
         ex_b         <= '0;
         ex_rd        <= 5'd0;
         ex_reg_write <= 1'b0;
         ex_illegal   <= 1'b0;
         illegal_cnt  <= '0;
      end else if (flush) begin
         ex_valid     <= 1'b0;
         ex_alu_op    <= 6'b000000;
         ex_a         <= '0;
         ex_b         <= '0;
         ex_rd        <= 5'd0;
         ex_reg_write <= 1'b0;
         ex_illegal   <= 1'b0;
      end else if (!stall) begin
         ex_valid <= if_valid;
         if (if_valid && d_legal) begin
            ex_alu_op    <= d_op;
            ex_a         <= d_a;
            ex_b         <= d_b;
            ex_rd        <= d_rd;
            ex_reg_write <= (d_rd != 5'd0);
            ex_illegal   <= 1'b0;
         end else begin
            ex_alu_op    <= 6'b000000;
            ex_a         <= '0;
            ex_b         <= '0;
            ex_rd        <= 5'd0;
            ex_reg_write <= 1'b0;
            ex_illegal   <= if_valid;
            if (if_valid && (illegal_cnt != {CNT_W{1'b1}}))
               illegal_cnt <= illegal_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_id_alu_issue.sv
// Directed bench for id_alu_issue: a decode vector table plus stall/flush, saturation and reset sequences.
module tb_id_alu_issue;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] if_instr;
   logic        if_valid, s_valid;
   logic [31:0] rs_data, rt_data;
   logic        stall, flush;

   logic        ex_valid, ex_reg_write, ex_illegal;
   logic [5:0]  ex_alu_op;
   logic [31:0] ex_a, ex_b;
   logic [4:0]  ex_rd;
   logic [15:0] illegal_cnt;

   logic        s_ex_valid, s_ex_reg_write, s_ex_illegal;
   logic [5:0]  s_ex_alu_op;
   logic [31:0] s_ex_a, s_ex_b;
   logic [4:0]  s_ex_rd;
   logic [1:0]  s_illegal_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_alu_issue #(.DATA_W(32), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .if_instr(if_instr), .if_valid(if_valid),
      .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_a(ex_a), .ex_b(ex_b),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal),
      .illegal_cnt(illegal_cnt)
   );

   id_alu_issue #(.DATA_W(32), .CNT_W(2)) dut_small (
      .clk(clk), .reset(reset), .if_instr(if_instr), .if_valid(s_valid),
      .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
      .ex_valid(s_ex_valid), .ex_alu_op(s_ex_alu_op), .ex_a(s_ex_a), .ex_b(s_ex_b),
      .ex_rd(s_ex_rd), .ex_reg_write(s_ex_reg_write), .ex_illegal(s_ex_illegal),
      .illegal_cnt(s_illegal_cnt)
   );

   typedef struct {
      logic [31:0] instr;
      logic        valid;
      logic [31:0] rs;
      logic [31:0] rt;
      logic        ev;
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        rw;
      logic        ill;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(logic [31:0] instr, logic valid, logic [31:0] rs, logic [31:0] rt,
                               logic ev, logic [5:0] op, logic [31:0] a, logic [31:0] b,
                               logic [4:0] rd, logic rw, logic ill);
      vec_t v;
      v.instr = instr; v.valid = valid; v.rs = rs; v.rt = rt;
      v.ev = ev; v.op = op; v.a = a; v.b = b; v.rd = rd; v.rw = rw; v.ill = ill;
      return v;
   endfunction

   function automatic logic [77:0] pack_exp(logic ev, logic [5:0] op, logic [31:0] a, logic [31:0] b,
                                            logic [4:0] rd, logic rw, logic ill);
      return {ev, op, a, b, rd, rw, ill};
   endfunction

   function automatic logic [77:0] pack_dut();
      return {ex_valid, ex_alu_op, ex_a, ex_b, ex_rd, ex_reg_write, ex_illegal};
   endfunction

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic [31:0] instr, input logic valid, input logic [31:0] rs,
                       input logic [31:0] rt, input logic st, input logic fl);
      @(negedge clk);
      if_instr = instr; if_valid = valid; rs_data = rs; rt_data = rt;
      stall = st; flush = fl;
      @(posedge clk);
      #1;
   endtask

   logic [15:0] exp_cnt;
   logic [77:0] held;

   initial begin
      reset = 1'b1; if_instr = '0; if_valid = 1'b0; s_valid = 1'b0;
      rs_data = '0; rt_data = '0; stall = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {18'd0, pack_dut()}, 96'd0);
      check("reset_cnt", {80'd0, illegal_cnt}, 96'd0);
      @(negedge clk);
      reset = 1'b0;

      tbl[0]  = mk(32'h00221820, 1, 32'd5, 32'd7, 1, 6'h20, 32'd5, 32'd7, 5'd3, 1, 0);
      tbl[1]  = mk(32'h2024FFFE, 1, 32'd5, 32'd9, 1, 6'h20, 32'd5, 32'hFFFFFFFE, 5'd4, 1, 0);
      tbl[2]  = mk(32'h34258000, 1, 32'd3, 32'd9, 1, 6'h25, 32'd3, 32'h00008000, 5'd5, 1, 0);
      tbl[3]  = mk(32'h00031100, 1, 32'd9, 32'd1, 1, 6'h00, 32'd1, 32'd4, 5'd2, 1, 0);
      tbl[4]  = mk(32'h00000000, 1, 32'd9, 32'h55, 1, 6'h00, 32'h55, 32'd0, 5'd0, 0, 0);
      tbl[5]  = mk(32'h00433004, 1, 32'h12, 32'hAB, 1, 6'h04, 32'hAB, 32'h12, 5'd6, 1, 0);
      tbl[6]  = mk(32'h2C27FFFF, 1, 32'd1, 32'd0, 1, 6'h2B, 32'd1, 32'hFFFFFFFF, 5'd7, 1, 0);
      tbl[7]  = mk(32'h30288001, 1, 32'hF0F0, 32'd0, 1, 6'h24, 32'hF0F0, 32'h00008001, 5'd8, 1, 0);
      tbl[8]  = mk(32'h3C091234, 1, 32'd77, 32'd88, 1, 6'h00, 32'h1234, 32'd16, 5'd9, 1, 0);
      tbl[9]  = mk(32'h00221801, 1, 32'd5, 32'd7, 1, 6'h00, 32'd0, 32'd0, 5'd0, 0, 1);
      tbl[10] = mk(32'hFC000000, 0, 32'd5, 32'd7, 0, 6'h00, 32'd0, 32'd0, 5'd0, 0, 0);
      tbl[11] = mk(32'h00220020, 1, 32'd5, 32'd7, 1, 6'h20, 32'd5, 32'd7, 5'd0, 0, 0);
      tbl[12] = mk(32'h0022182A, 1, 32'd5, 32'd7, 1, 6'h2A, 32'd5, 32'd7, 5'd3, 1, 0);
      tbl[13] = mk(32'h00221807, 1, 32'd3, 32'h80000000, 1, 6'h07, 32'h80000000, 32'd3, 5'd3, 1, 0);
      tbl[14] = mk(32'h00221820, 0, 32'd5, 32'd7, 0, 6'h00, 32'd0, 32'd0, 5'd0, 0, 0);

      exp_cnt = 16'd0;
      for (int i = 0; i < 15; i++) begin
         step(tbl[i].instr, tbl[i].valid, tbl[i].rs, tbl[i].rt, 1'b0, 1'b0);
         if (tbl[i].valid && tbl[i].ill) exp_cnt = exp_cnt + 16'd1;
         check($sformatf("vec%0d", i), {18'd0, pack_dut()},
               {18'd0, pack_exp(tbl[i].ev, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].rw, tbl[i].ill)});
         check($sformatf("vec%0d_cnt", i), {80'd0, illegal_cnt}, {80'd0, exp_cnt});
      end

      // Load ADD, then hold it across three stalled cycles with different (and illegal) inputs.
      step(32'h00221820, 1, 32'd5, 32'd7, 1'b0, 1'b0);
      held = pack_exp(1, 6'h20, 32'd5, 32'd7, 5'd3, 1, 0);
      check("stall_load", {18'd0, pack_dut()}, {18'd0, held});
      step(32'h2024FFFE, 1, 32'd1, 32'd2, 1'b1, 1'b0);
      check("stall_1", {18'd0, pack_dut()}, {18'd0, held});
      step(32'hFC000000, 1, 32'd1, 32'd2, 1'b1, 1'b0);
      check("stall_2", {18'd0, pack_dut()}, {18'd0, held});
      step(32'h00000000, 0, 32'd1, 32'd2, 1'b1, 1'b0);
      check("stall_3", {18'd0, pack_dut()}, {18'd0, held});
      check("stall_cnt", {80'd0, illegal_cnt}, {80'd0, exp_cnt});
      step(32'h2024FFFE, 1, 32'd1, 32'd2, 1'b1, 1'b1);
      check("stall_flush", {18'd0, pack_dut()}, 96'd0);

      // Illegal flushed away by flush: counter unchanged.
      step(32'hFC000000, 1, 32'd1, 32'd2, 1'b0, 1'b1);
      check("flush_cnt", {80'd0, illegal_cnt}, {80'd0, exp_cnt});

      // Two-bit counter saturates at 3.
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         step(32'hFC000000, 1, 32'd1, 32'd2, 1'b0, 1'b0);
         exp_cnt = exp_cnt + 16'd1;
         check($sformatf("sat_cnt%0d", i), {94'd0, s_illegal_cnt}, (i < 3) ? 96'(i + 1) : 96'd3);
         check($sformatf("sat_ill%0d", i), {95'd0, s_ex_illegal}, 96'd1);
         check($sformatf("sat_rw%0d", i), {95'd0, s_ex_reg_write}, 96'd0);
      end
      check("main_cnt", {80'd0, illegal_cnt}, {80'd0, exp_cnt});
      s_valid = 1'b0;
      step(32'hFC000000, 0, 32'd1, 32'd2, 1'b0, 1'b0);
      check("sat_invalid_cnt", {94'd0, s_illegal_cnt}, 96'd3);
      check("sat_invalid_ill", {95'd0, s_ex_illegal}, 96'd0);

      // Reset overrides stall on a loaded instruction.
      step(32'h00221820, 1, 32'd5, 32'd7, 1'b0, 1'b0);
      check("pre_reset", {18'd0, pack_dut()}, {18'd0, held});
      @(negedge clk);
      reset = 1'b1; stall = 1'b1;
      @(posedge clk);
      #1;
      check("reset_stall", {18'd0, pack_dut()}, 96'd0);
      check("reset_cnt_main", {80'd0, illegal_cnt}, 96'd0);
      check("reset_cnt_small", {94'd0, s_illegal_cnt}, 96'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
